// File: rtl/muldiv_seq.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, stalling the pipeline until HI/LO are committed.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    input  logic             wr_hiE,
    input  logic             wr_loE,
    input  logic [WIDTH-1:0] wdataE,
    output logic             stallMD,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   srca_q, srca_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               divzero_q, divzero_d;

    logic               is_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_next;
    logic [WIDTH:0]     div_pr, div_diff, div_rem;
    logic               div_borrow;
    logic [2*WIDTH:0]   div_next;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    assign is_signed = ~opE[0];
    assign abs_a     = (is_signed && srcaE[WIDTH-1]) ? -srcaE : srcaE;
    assign abs_b     = (is_signed && srcbE[WIDTH-1]) ? -srcbE : srcbE;

    // Multiply: acc = {upper partial sum, remaining multiplier bits}, shifted right each step.
    assign addend   = acc_q[0] ? opnd_q : '0;
    assign mul_sum  = acc_q[2*WIDTH:WIDTH] + {1'b0, addend};
    assign mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits becoming quotient bits}.
    assign div_pr     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_borrow = div_pr < {1'b0, opnd_q};
    assign div_diff   = div_pr - {1'b0, opnd_q};
    assign div_rem    = div_borrow ? div_pr : div_diff;
    assign div_next   = {div_rem, acc_q[WIDTH-2:0], ~div_borrow};

    assign prod_s = neg_lo_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    assign quo_s  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_s  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        srca_d    = srca_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;
        case (state_q)
            S_IDLE: begin
                if (startE && !flushE) begin
                    is_div_d  = opE[1];
                    srca_d    = srcaE;
                    neg_lo_d  = is_signed & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                    neg_hi_d  = is_signed & srcaE[WIDTH-1];
                    opnd_d    = opE[1] ? abs_b : abs_a;
                    acc_d     = {{(WIDTH+1){1'b0}}, (opE[1] ? abs_a : abs_b)};
                    count_d   = '0;
                    divzero_d = 1'b0;
                    if (opE[1] && (srcbE == '0)) begin
                        divzero_d = 1'b1;
                        state_d   = S_FIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    if (wr_hiE) hi_d = wdataE;
                    if (wr_loE) lo_d = wdataE;
                end
            end
            S_RUN: begin
                if (flushE) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = is_div_q ? div_next : mul_next;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (!flushE) begin
                    done_d = 1'b1;
                    if (is_div_q && divzero_q) begin
                        hi_d = srca_q;
                        lo_d = '1;
                    end else if (is_div_q) begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end else begin
                        {hi_d, lo_d} = prod_s;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            srca_q    <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            srca_q    <= srca_d;
            is_div_q  <= is_div_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign stallMD = (startE && (state_q == S_IDLE) && !flushE) || busy;
    assign done    = done_q;
    assign divzero = divzero_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized ops against
// a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_seq;
    localparam int W = 32;

    logic         clk, reset, startE, flushE, wr_hiE, wr_loE;
    logic [1:0]   opE;
    logic [W-1:0] srcaE, srcbE, wdataE;
    logic         stallMD, busy, done, divzero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int passes = 0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .startE(startE), .opE(opE),
        .srcaE(srcaE), .srcbE(srcbE), .flushE(flushE),
        .wr_hiE(wr_hiE), .wr_loE(wr_loE), .wdataE(wdataE),
        .stallMD(stallMD), .busy(busy), .done(done), .divzero(divzero),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {hi, lo} from the architectural definition using 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: p = sa * sb;
            2'd1: p = {32'b0, a} * {32'b0, b};
            2'd2: if (b == 0) p = {a, 32'hFFFF_FFFF};
                  else begin p[31:0] = 32'(sa / sb); p[63:32] = 32'(sa % sb); end
            default: if (b == 0) p = {a, 32'hFFFF_FFFF};
                     else p = {a % b, a / b};
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'(($urandom_range(0, 15)));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issues one request and observes stall cycles, done pulses and done arrival (edges after accept).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit wr_lo_too, input logic [31:0] wd,
                          output int n_stall, output int n_done, output int t_done);
        @(negedge clk);
        startE = 1'b1; opE = op; srcaE = a; srcbE = b; wr_loE = wr_lo_too; wdataE = wd;
        n_stall = 0; n_done = 0; t_done = -1;
        for (int c = 0; c < 80; c++) begin
            if (c > 0) begin
                @(negedge clk);
                startE = 1'b0; wr_loE = 1'b0;
            end
            #1;
            if (stallMD) n_stall++;
            if (done) begin
                n_done++;
                if (t_done < 0) t_done = c;
            end
            if (t_done >= 0 && c > t_done) break;
        end
        startE = 1'b0; wr_loE = 1'b0;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h divzero=%0b stall=%0d done_at=%0d",
                 op, a, b, hi, lo, divzero, n_stall, t_done);
    endtask

    task automatic test_reset();
        reset = 1'b1; startE = 0; flushE = 0; wr_hiE = 0; wr_loE = 0;
        opE = 0; srcaE = 0; srcbE = 0; wdataE = 0;
        #2;
        checks++;
        if ({stallMD, busy, done, divzero, hi, lo} !== '0)
            $display("FAIL reset_outputs: got %b/%b/%b/%b %h %h required all zero", stallMD, busy, done, divzero, hi, lo);
        else passes++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk); wr_hiE = 1; wdataE = 32'h1234;
        @(negedge clk); wr_hiE = 0; wr_loE = 1; wdataE = 32'h5678;
        @(negedge clk); wr_loE = 0;
        #1;
        checks++;
        if ({hi, lo} !== {32'h0000_1234, 32'h0000_5678})
            $display("FAIL mthi_mtlo: got hi=%h lo=%h required 00001234 00005678", hi, lo);
        else passes++;
        $display("mthi/mtlo -> hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_flush();
        int n_done;
        @(negedge clk); startE = 1; flushE = 1; opE = 2'd0; srcaE = 3; srcbE = 4;
        #1;
        checks++;
        if (stallMD !== 1'b0) $display("FAIL flush_idle_stall: got %b required 0", stallMD);
        else passes++;
        @(negedge clk); flushE = 0;
        checks++;
        if (busy !== 1'b0) $display("FAIL flush_idle_ignored: busy got %b required 0", busy);
        else passes++;
        repeat (11) begin
            @(negedge clk); startE = 0;
        end
        flushE = 1;
        @(negedge clk); flushE = 0;
        #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL flush_run_idle: busy got %b required 0", busy);
        else passes++;
        n_done = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (done) n_done++;
        end
        checks++;
        if (n_done !== 0) $display("FAIL flush_no_done: got %0d pulses required 0", n_done);
        else passes++;
        checks++;
        if ({hi, lo} !== {32'h0000_1234, 32'h0000_5678})
            $display("FAIL flush_hilo_kept: got hi=%h lo=%h required 00001234 00005678", hi, lo);
        else passes++;
        $display("flush mid-run -> hi=%h lo=%h busy=%0b", hi, lo, busy);
    endtask

    task automatic test_directed();
        logic [1:0]  d_op [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        logic [31:0] d_a  [5] = '{32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
        logic [31:0] d_b  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h2, 32'd7, 32'hFFFF_FFFF};
        logic [63:0] d_x  [5] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFE_0000_0001,
                                  64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                                  64'h0000_0000_8000_0000};
        int n_stall, n_done, t_done;
        for (int i = 0; i < 5; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], 1'b0, 32'h0, n_stall, n_done, t_done);
            checks++;
            if ({hi, lo} !== d_x[i])
                $display("FAIL directed_%0d_result: got %h_%h required %h", i, hi, lo, d_x[i]);
            else passes++;
            checks++;
            if (n_stall !== W + 2) $display("FAIL directed_%0d_stall: got %0d required %0d", i, n_stall, W + 2);
            else passes++;
            checks++;
            if (n_done !== 1 || t_done !== W + 2)
                $display("FAIL directed_%0d_done: got %0d pulses at %0d required 1 at %0d", i, n_done, t_done, W + 2);
            else passes++;
        end
    endtask

    task automatic test_divzero();
        int n_stall, n_done, t_done;
        run_op(2'd3, 32'd5, 32'd0, 1'b0, 32'h0, n_stall, n_done, t_done);
        checks++;
        if ({divzero, hi, lo} !== {1'b1, 32'h5, 32'hFFFF_FFFF})
            $display("FAIL divzero_result: got %b %h %h required 1 00000005 ffffffff", divzero, hi, lo);
        else passes++;
        checks++;
        if (n_done !== 1 || t_done !== 2)
            $display("FAIL divzero_latency: got %0d pulses at %0d required 1 at 2", n_done, t_done);
        else passes++;
        run_op(2'd1, 32'd2, 32'd3, 1'b0, 32'h0, n_stall, n_done, t_done);
        checks++;
        if ({divzero, hi, lo} !== {1'b0, 32'h0, 32'h6})
            $display("FAIL divzero_cleared: got %b %h %h required 0 00000000 00000006", divzero, hi, lo);
        else passes++;
    endtask

    task automatic test_start_with_write();
        int n_stall, n_done, t_done;
        run_op(2'd1, 32'd6, 32'd7, 1'b1, 32'hDEAD, n_stall, n_done, t_done);
        checks++;
        if ({hi, lo} !== {32'h0, 32'd42})
            $display("FAIL start_with_write: got hi=%h lo=%h required 00000000 0000002a", hi, lo);
        else passes++;
    endtask

    task automatic test_busy_writes();
        int t_done;
        @(negedge clk); startE = 1; opE = 2'd1; srcaE = 5; srcbE = 5;
        @(negedge clk); startE = 0;
        repeat (3) @(negedge clk);
        wr_hiE = 1; wr_loE = 1; wdataE = 32'hAAAA;
        @(negedge clk); wr_hiE = 0; wr_loE = 0;
        t_done = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #1;
            if (done) begin t_done = c; break; end
        end
        checks++;
        if (t_done < 0 || {hi, lo} !== {32'h0, 32'd25})
            $display("FAIL busy_writes_ignored: got hi=%h lo=%h done_at=%0d required 00000000 00000019", hi, lo, t_done);
        else passes++;
        $display("writes while busy -> hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_random();
        int n_stall, n_done, t_done, t_exp;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp_r;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            exp_r = model(op, a, b);
            t_exp = (op[1] && b == 0) ? 2 : W + 2;
            run_op(op, a, b, 1'b0, 32'h0, n_stall, n_done, t_done);
            checks++;
            if ({hi, lo} !== exp_r)
                $display("FAIL random_%0d_result: op=%0d a=%h b=%h got %h_%h required %h", i, op, a, b, hi, lo, exp_r);
            else passes++;
            checks++;
            if (n_done !== 1 || t_done !== t_exp || divzero !== (op[1] && b == 0))
                $display("FAIL random_%0d_timing: got %0d pulses at %0d divzero=%b required 1 at %0d", i, n_done, t_done, divzero, t_exp);
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); startE = 1; opE = 2'd0; srcaE = 32'h1234_5678; srcbE = 32'h9;
        @(negedge clk); startE = 0;
        repeat (4) @(negedge clk);
        #2 reset = 1;
        #1;
        checks++;
        if ({stallMD, busy, done, divzero, hi, lo} !== '0)
            $display("FAIL async_reset_mid_run: got %b/%b/%b/%b %h %h required all zero", stallMD, busy, done, divzero, hi, lo);
        else passes++;
        @(negedge clk); reset = 0;
        $display("async reset mid-run -> hi=%h lo=%h busy=%0b", hi, lo, busy);
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_flush();
        test_directed();
        test_divzero();
        test_start_with_write();
        test_busy_writes();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer owning the HI/LO register pair for the pipelined MIPS core.
- Accepts one MULT/MULTU/DIV/DIVU request from the execute stage and runs a radix-2 shift-add or restoring-divide engine, one bit per cycle.
- Drives the pipeline stall for the whole operation and commits HI/LO at completion.
- Also services MTHI/MTLO writes and supplies HI/LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- startE  in  1  request valid from execute stage.
- opE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srcaE  in  WIDTH  multiplicand / dividend (rs).
- srcbE  in  WIDTH  multiplier / divisor (rt).
- flushE  in  1  exception abort.
- wr_hiE  in  1  MTHI write enable.
- wr_loE  in  1  MTLO write enable.
- wdataE  in  WIDTH  MTHI/MTLO data.
- stallMD  out  1  freeze request to fetch, decode and execute.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on the cycle after HI/LO commit.
- divzero  out  1  sticky flag: last divide had a zero divisor; cleared by the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async): state=IDLE, count=0, hi=0, lo=0, busy=0, done=0, divzero=0, stallMD=0.
- States: IDLE, RUN, FIN.
- IDLE:
  - If startE=1 and flushE=0: latch operands, compute absolute values (signed ops only), record result signs, clear divzero, count=0.
  - Next state is RUN, except divide with srcbE=0, which goes straight to FIN with divzero=1.
  - Else if wr_hiE/wr_loE: write hi/lo from wdataE. Both may be set in the same cycle. startE has priority; writes that coincide with an accepted start are dropped.
- RUN: one iteration per cycle, count increments.
  - Mult: 2*WIDTH-bit accumulator shift-add on |a|*|b|.
  - Div: restoring shift-subtract of |a| by |b|.
  - After WIDTH iterations (count=WIDTH-1 at the edge), go to FIN.
- FIN: apply signs and write hi/lo at the edge, then go to IDLE.
  - Mult: {hi,lo} = signed/unsigned 2*WIDTH-bit product.
  - Div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Divide by zero: hi = srcaE as latched, lo = all ones.
- done pulses high for exactly one cycle after the FIN edge.
- Latency, normal op: start edge, WIDTH RUN edges, FIN edge, i.e. WIDTH+2 edges from accept to HI/LO visible.
- Latency, divide by zero: 2 edges.
- stallMD = (startE & state==IDLE & ~flushE) | (state != IDLE). The issuing instruction is held in execute until the result is committed. MFHI/MFLO behind it therefore sees the committed value, and no extra forwarding is needed.
- flushE in RUN or FIN: return to IDLE next edge; hi/lo unchanged; no done; divzero unchanged.
- flushE with startE in IDLE: request ignored.
- startE while busy: ignored. The pipeline is stalled, so the request is re-presented until accepted.
- wr_hiE/wr_loE while busy: ignored.
- Width rule: all arithmetic is internal at 2*WIDTH+1 bits. The most negative dividend / -1 yields lo=most negative value, hi=0, with no trap.
- Reset mid-operation: immediate return to the reset state.

Test Plan:
- MULT 7 * 0xFFFFFFFD -> stallMD high for 34 cycles; then hi=FFFFFFFF, lo=FFFFFFEB; done one cycle.
- MULTU FFFFFFFF * FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- DIV FFFFFFF9 / 2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU 100 / 7 -> lo=0000000E, hi=00000002.
- DIV 0x80000000 / FFFFFFFF -> lo=80000000, hi=0.
- DIVU 5 / 0 -> divzero=1, hi=00000005, lo=FFFFFFFF, done 2 edges after start.
- MULT 3*4 with flushE at RUN count 10 -> back to IDLE, hi/lo keep prior values, no done.
- Async reset mid-RUN -> all outputs 0.
- MTHI 0x1234 then MTLO 0x5678 in IDLE -> hi=00001234, lo=00005678.
- MTLO issued concurrently with startE -> write dropped, product written.
